// File: rtl/wisc_pkg.sv
// Shared constants and types for the WISC instruction-fetch front end.
package wisc_pkg;

    localparam int INSTR_W = 16;
    localparam int OP_W    = 5;

    localparam logic [OP_W-1:0] OP_HALT = 5'b00000;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b00001;
    localparam logic [OP_W-1:0] OP_J    = 5'b00100;
    localparam logic [OP_W-1:0] OP_JR   = 5'b00101;
    localparam logic [OP_W-1:0] OP_JAL  = 5'b00110;
    localparam logic [OP_W-1:0] OP_JALR = 5'b00111;
    localparam logic [OP_W-1:0] OP_BEQZ = 5'b01100;
    localparam logic [OP_W-1:0] OP_BNEZ = 5'b01101;
    localparam logic [OP_W-1:0] OP_BLTZ = 5'b01110;
    localparam logic [OP_W-1:0] OP_BGEZ = 5'b01111;

    typedef enum logic {
        FS_RUN    = 1'b0,
        FS_HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {instr, pc} pairs; clr beats push/pop.
module fetch_queue #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic              do_push;
    logic              do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !clr;
    assign do_push = push && !clr && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// WISC fetch front end: PC register, fetch FSM, redirect and sticky error.
module fetch_unit
    import wisc_pkg::*;
#(
    parameter int               WIDTH    = INSTR_W,
    parameter int               INC      = 2,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               DEPTH    = 2,
    parameter logic [OP_W-1:0]  HALT_OP  = OP_HALT
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_en,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             redir_valid,
    input  logic [WIDTH-1:0] redir_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_instr,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_pc_next,
    output logic             halted,
    output logic             err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int DW = 2 * WIDTH;

    fetch_state_t     state;
    logic [WIDTH-1:0] pc;
    logic [WIDTH:0]   pc_inc;
    logic [CW-1:0]    q_count;
    logic             q_full;
    logic             q_empty;
    logic [DW-1:0]    q_dout;
    logic             running;
    logic             pop;
    logic             push_ok;
    logic             push;
    logic             is_halt;

    // A redirect or reset suppresses both fetch and delivery this cycle.
    assign running   = (state == FS_RUN) && !rst && !redir_valid;
    assign out_valid = !q_empty && !rst && !redir_valid;
    assign pop       = out_valid && out_ready;
    assign push_ok   = (q_count < CW'(DEPTH)) || pop;
    assign push      = running && push_ok;

    assign imem_en   = push;
    assign imem_addr = pc;
    assign pc_inc    = {1'b0, pc} + (WIDTH + 1)'(INC);
    assign is_halt   = (imem_rdata[WIDTH-1 -: OP_W] == HALT_OP);
    assign halted    = (state == FS_HALTED) && !rst;

    assign out_instr   = q_dout[DW-1 -: WIDTH];
    assign out_pc      = q_dout[WIDTH-1:0];
    assign out_pc_next = out_pc + WIDTH'(INC);

    fetch_queue #(
        .DEPTH  (DEPTH),
        .DATA_W (DW)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .clr   (redir_valid),
        .push  (push),
        .pop   (pop),
        .din   ({imem_rdata, pc}),
        .dout  (q_dout),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_PC;
            state <= FS_RUN;
            err   <= 1'b0;
        end else if (redir_valid) begin
            pc    <= {redir_pc[WIDTH-1:1], 1'b0};
            state <= FS_RUN;
            if (redir_pc[0]) begin
                err <= 1'b1;
            end
        end else if (push) begin
            pc <= pc_inc[WIDTH-1:0];
            if (pc_inc[WIDTH]) begin
                err <= 1'b1;
            end
            if (is_halt) begin
                state <= FS_HALTED;
            end
        end
    end

    a_full_count: assert property (
        @(posedge clk) q_full == (q_count == CW'(DEPTH))
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: three DEPTH variants against a list-based model.
module tb_fetch_unit;

    localparam logic [15:0] NOP = 16'h0800;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic redir_valid = 1'b0;
    logic [15:0] redir_pc = '0;
    logic out_ready = 1'b0;

    logic [2:0] imem_en;
    logic [2:0] out_valid;
    logic [2:0] halted;
    logic [2:0] err;
    logic [2:0][15:0] imem_addr;
    logic [2:0][15:0] imem_rdata;
    logic [2:0][15:0] out_instr;
    logic [2:0][15:0] out_pc;
    logic [2:0][15:0] out_pc_next;

    logic [15:0] mem [0:65535];

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mq [3][4];
    int          msz [3];
    logic [15:0] mpc [3];
    bit          mhalt [3];
    bit          merr [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign imem_rdata[g] = mem[imem_addr[g]];
        fetch_unit #(.DEPTH(g + 2)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .imem_en     (imem_en[g]),
            .imem_addr   (imem_addr[g]),
            .imem_rdata  (imem_rdata[g]),
            .redir_valid (redir_valid),
            .redir_pc    (redir_pc),
            .out_valid   (out_valid[g]),
            .out_ready   (out_ready),
            .out_instr   (out_instr[g]),
            .out_pc      (out_pc[g]),
            .out_pc_next (out_pc_next[g]),
            .halted      (halted[g]),
            .err         (err[g])
        );
    end

    function automatic bit ex_valid(int k);
        return !rst && !redir_valid && msz[k] > 0;
    endfunction

    function automatic bit ex_en(int k);
        return !rst && !redir_valid && !mhalt[k] &&
               (msz[k] < k + 2 || (ex_valid(k) && out_ready));
    endfunction

    task automatic tick();
        for (int k = 0; k < 3; k++) begin
            bit v;
            bit en;
            logic [16:0] s;
            v  = ex_valid(k);
            en = ex_en(k);
            if (rst) begin
                msz[k] = 0; mpc[k] = 16'h0; mhalt[k] = 0; merr[k] = 0;
            end else if (redir_valid) begin
                msz[k] = 0; mhalt[k] = 0;
                mpc[k] = {redir_pc[15:1], 1'b0};
                if (redir_pc[0]) merr[k] = 1;
            end else begin
                if (v && out_ready) begin
                    for (int i = 0; i < 3; i++) mq[k][i] = mq[k][i+1];
                    msz[k]--;
                end
                if (en) begin
                    mq[k][msz[k]] = {mem[mpc[k]], mpc[k]};
                    msz[k]++;
                    if (mem[mpc[k]][15:11] == 5'b0) mhalt[k] = 1;
                    s = {1'b0, mpc[k]} + 17'd2;
                    if (s[16]) merr[k] = 1;
                    mpc[k] = s[15:0];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redir_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #2;
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (imem_en[k] !== 1'b0 || out_valid[k] !== 1'b0 || halted[k] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL reset_outs dut%0d: en/valid/halted %b%b%b want 000",
                             k, imem_en[k], out_valid[k], halted[k]);
                end
            end
            tick();
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (imem_en[k] !== 1'b1 || imem_addr[k] !== 16'(2 * c)) begin
                    n_bad++;
                    $display("FAIL reset_addr dut%0d c%0d: en %b addr %h want 1 %h",
                             k, c, imem_en[k], imem_addr[k], 16'(2 * c));
                end
                n_cmp++;
                if (out_valid[k] !== (c != 0) || err[k] !== 1'b0 ||
                    (c != 0 && out_pc[k] !== 16'(2 * (c - 1)))) begin
                    n_bad++;
                    $display("FAIL reset_head dut%0d c%0d: valid %b pc %h err %b",
                             k, c, out_valid[k], out_pc[k], err[k]);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int fetches;
        logic [15:0] exp_pc;
        out_ready = 1'b0;
        do_reset();
        fetches = 0;
        for (int c = 0; c < 5; c++) begin
            #2;
            if (imem_en[0]) fetches++;
            if (c >= 2) begin
                n_cmp++;
                if (imem_en[0] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL bp_stall c%0d: imem_en %b want 0", c, imem_en[0]);
                end
            end
            if (c >= 1) begin
                n_cmp++;
                if (out_valid[0] !== 1'b1 || out_pc[0] !== 16'h0 || out_instr[0] !== mem[0]) begin
                    n_bad++;
                    $display("FAIL bp_hold c%0d: valid %b pc %h instr %h want 1 0000 %h",
                             c, out_valid[0], out_pc[0], out_instr[0], mem[0]);
                end
            end
            tick();
        end
        n_cmp++;
        if (fetches != 2) begin
            n_bad++;
            $display("FAIL bp_fetches: got %0d want 2", fetches);
        end
        out_ready = 1'b1;
        exp_pc = 16'h0;
        for (int c = 0; c < 8; c++) begin
            #2;
            if (out_valid[0]) begin
                n_cmp++;
                if (out_pc[0] !== exp_pc) begin
                    n_bad++;
                    $display("FAIL bp_order c%0d: out_pc %h want %h", c, out_pc[0], exp_pc);
                end
                exp_pc = exp_pc + 16'd2;
            end
            tick();
        end
        n_cmp++;
        if (exp_pc !== 16'd16) begin
            n_bad++;
            $display("FAIL bp_resume: next pc %h want 0010", exp_pc);
        end
    endtask

    task automatic test_redirect_full();
        out_ready = 1'b0;
        do_reset();
        repeat (3) begin #2; tick(); end
        redir_valid = 1'b1;
        redir_pc = 16'h0040;
        out_ready = 1'b1;
        #2;
        n_cmp++;
        if (out_valid[0] !== 1'b0 || imem_en[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL redir_cycle: valid %b en %b want 0 0", out_valid[0], imem_en[0]);
        end
        tick();
        redir_valid = 1'b0;
        #2;
        n_cmp++;
        if (imem_addr[0] !== 16'h0040 || imem_en[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL redir_fetch: addr %h en %b valid %b want 0040 1 0",
                     imem_addr[0], imem_en[0], out_valid[0]);
        end
        tick();
        #2;
        n_cmp++;
        if (out_valid[0] !== 1'b1 || out_pc[0] !== 16'h0040 || out_pc_next[0] !== 16'h0042) begin
            n_bad++;
            $display("FAIL redir_head: valid %b pc %h next %h want 1 0040 0042",
                     out_valid[0], out_pc[0], out_pc_next[0]);
        end
        tick();
    endtask

    task automatic test_halt();
        logic [15:0] last;
        mem[16'h0006] = 16'h0000;
        out_ready = 1'b1;
        do_reset();
        repeat (4) begin #2; tick(); end
        last = 16'hFFFF;
        for (int c = 0; c < 4; c++) begin
            #2;
            if (out_valid[0]) last = out_pc[0];
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (halted[k] !== 1'b1 || imem_en[k] !== 1'b0 || (c == 3 && out_valid[k] !== 1'b0)) begin
                    n_bad++;
                    $display("FAIL halt_hold dut%0d c%0d: halted %b en %b valid %b",
                             k, c, halted[k], imem_en[k], out_valid[k]);
                end
            end
            tick();
        end
        n_cmp++;
        if (last !== 16'h0006) begin
            n_bad++;
            $display("FAIL halt_drain: last out_pc %h want 0006", last);
        end
        redir_valid = 1'b1;
        redir_pc = 16'h0010;
        #2;
        tick();
        redir_valid = 1'b0;
        #2;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (halted[k] !== 1'b0 || imem_en[k] !== 1'b1 || imem_addr[k] !== 16'h0010) begin
                n_bad++;
                $display("FAIL halt_exit dut%0d: halted %b en %b addr %h want 0 1 0010",
                         k, halted[k], imem_en[k], imem_addr[k]);
            end
        end
        tick();
        mem[16'h0006] = NOP;
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        do_reset();
        #2; tick();
        redir_valid = 1'b1;
        redir_pc = 16'hFFFE;
        #2; tick();
        redir_valid = 1'b0;
        #2;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (imem_addr[k] !== 16'hFFFE || imem_en[k] !== 1'b1 || err[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL wrap_fetch dut%0d: addr %h en %b err %b want fffe 1 0",
                         k, imem_addr[k], imem_en[k], err[k]);
            end
        end
        tick();
        #2;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (err[k] !== 1'b1 || imem_addr[k] !== 16'h0000) begin
                n_bad++;
                $display("FAIL wrap_err dut%0d: err %b addr %h want 1 0000", k, err[k], imem_addr[k]);
            end
        end
        tick();
        repeat (5) begin #2; tick(); end
        #2;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (err[k] !== 1'b1) begin
                n_bad++;
                $display("FAIL wrap_sticky dut%0d: err %b want 1", k, err[k]);
            end
        end
        do_reset();
        #2;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (err[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL wrap_clear dut%0d: err %b want 0", k, err[k]);
            end
        end
        tick();
    endtask

    task automatic test_misaligned();
        out_ready = 1'b1;
        do_reset();
        redir_valid = 1'b1;
        redir_pc = 16'h0013;
        #2;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (err[k] !== 1'b0) begin
                n_bad++;
                $display("FAIL mis_pre dut%0d: err %b want 0", k, err[k]);
            end
        end
        tick();
        redir_valid = 1'b0;
        #2;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (err[k] !== 1'b1 || imem_addr[k] !== 16'h0012 || imem_en[k] !== 1'b1) begin
                n_bad++;
                $display("FAIL mis_target dut%0d: err %b addr %h en %b want 1 0012 1",
                         k, err[k], imem_addr[k], imem_en[k]);
            end
        end
        tick();
    endtask

    task automatic test_random();
        for (int a = 0; a < 65536; a++) begin
            if ($urandom_range(0, 15) == 0) mem[a] = {5'b0, 11'($urandom)};
            else mem[a] = {5'($urandom_range(1, 31)), 11'($urandom)};
        end
        out_ready = 1'b1;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            redir_valid = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0) redir_pc = 16'hFFF0 | 16'($urandom_range(0, 15));
            else redir_pc = 16'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 3) != 0);
            #2;
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (imem_en[k] !== ex_en(k) || imem_addr[k] !== mpc[k]) begin
                    n_bad++;
                    $display("FAIL rnd_fetch dut%0d c%0d: en %b addr %h want %b %h",
                             k, c, imem_en[k], imem_addr[k], ex_en(k), mpc[k]);
                end
                n_cmp++;
                if (out_valid[k] !== ex_valid(k)) begin
                    n_bad++;
                    $display("FAIL rnd_valid dut%0d c%0d: valid %b want %b",
                             k, c, out_valid[k], ex_valid(k));
                end
                if (ex_valid(k)) begin
                    n_cmp++;
                    if ({out_instr[k], out_pc[k]} !== mq[k][0] ||
                        out_pc_next[k] !== mq[k][0][15:0] + 16'd2) begin
                        n_bad++;
                        $display("FAIL rnd_head dut%0d c%0d: instr/pc %h%h want %h",
                                 k, c, out_instr[k], out_pc[k], mq[k][0]);
                    end
                end
                n_cmp++;
                if (halted[k] !== (!rst && mhalt[k]) || err[k] !== merr[k]) begin
                    n_bad++;
                    $display("FAIL rnd_status dut%0d c%0d: halted %b err %b want %b %b",
                             k, c, halted[k], err[k], !rst && mhalt[k], merr[k]);
                end
            end
            tick();
        end
        rst = 1'b0;
        redir_valid = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = NOP;
        test_reset();
        test_backpressure();
        test_redirect_full();
        test_halt();
        test_wrap();
        test_misaligned();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
